alu_iter: RTL

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// Iterative 32-bit ALU. Simple operations complete in one cycle; MULU and
// non-zero-divisor DIVU/REMU iterate one bit per cycle for 32 cycles.
//
// Handshake: start is a request sampled only while busy=0 (IDLE or DONE).
// The edge that samples start=1 captures A, B and ALUOp. done is a one-cycle
// pulse marking the cycle in which result/div_by_zero carry the new value.
// There is no back-pressure; a start during busy=1 is dropped.
module alu_iter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [3:0]  ALUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        zero,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [1:0]  fsm_state
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  count;
    logic [3:0]  op_q;
    // MULU: acc = partial product, work = multiplier (shifts right),
    //       oper = multiplicand (shifts left).
    // DIV:  acc = partial remainder, work = dividend/quotient, oper = divisor.
    logic [31:0] acc;
    logic [31:0] work;
    logic [31:0] oper;

    logic [31:0] quick_result;
    logic        is_div;
    logic        is_multi;
    logic        is_dbz;
    logic [31:0] mul_acc_nxt;
    logic [32:0] div_diff;
    logic        div_ok;
    logic [31:0] div_rem_nxt;
    logic [31:0] div_quo_nxt;
    logic [31:0] final_result;

    assign zero      = (result == 32'd0);
    assign fsm_state = state;

    // Single-cycle result and classification of the incoming request
    always_comb begin
        quick_result = 32'd0;
        case (ALUOp)
            OP_ADD:  quick_result = A + B;
            OP_SUB:  quick_result = A - B;
            OP_AND:  quick_result = A & B;
            OP_OR:   quick_result = A | B;
            OP_XOR:  quick_result = A ^ B;
            OP_SLT:  quick_result = {31'd0, ($signed(A) < $signed(B))};
            OP_SLL:  quick_result = B << A[4:0];
            OP_SRL:  quick_result = B >> A[4:0];
            OP_DIVU: quick_result = 32'hFFFF_FFFF;
            OP_REMU: quick_result = A;
            default: quick_result = 32'd0;
        endcase
        is_div   = (ALUOp == OP_DIVU) || (ALUOp == OP_REMU);
        is_dbz   = is_div && (B == 32'd0);
        is_multi = (ALUOp == OP_MULU) || (is_div && (B != 32'd0));
    end

    // One shift-add or restoring-divide step from the current work registers
    always_comb begin
        mul_acc_nxt  = acc + (work[0] ? oper : 32'd0);
        div_diff     = {acc, work[31]} - {1'b0, oper};
        div_ok       = ~div_diff[32];
        div_rem_nxt  = div_ok ? div_diff[31:0] : {acc[30:0], work[31]};
        div_quo_nxt  = {work[30:0], div_ok};
        final_result = 32'd0;
        case (op_q)
            OP_MULU: final_result = mul_acc_nxt;
            OP_DIVU: final_result = div_quo_nxt;
            OP_REMU: final_result = div_rem_nxt;
            default: final_result = 32'd0;
        endcase
    end

    // Control FSM with registered outputs; the iteration datapath is kept
    // apart from result so result never moves mid-CALC
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            count       <= 6'd0;
            op_q        <= 4'd0;
            acc         <= 32'd0;
            work        <= 32'd0;
            oper        <= 32'd0;
            result      <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q <= ALUOp;
                        if (is_multi) begin
                            state <= CALC;
                            busy  <= 1'b1;
                            count <= 6'd0;
                            acc   <= 32'd0;
                            if (ALUOp == OP_MULU) begin
                                work <= B;
                                oper <= A;
                            end else begin
                                work <= A;
                                oper <= B;
                            end
                        end else begin
                            state       <= DONE;
                            done        <= 1'b1;
                            result      <= quick_result;
                            div_by_zero <= is_dbz;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    count <= count + 6'd1;
                    if (op_q == OP_MULU) begin
                        acc  <= mul_acc_nxt;
                        work <= work >> 1;
                        oper <= oper << 1;
                    end else begin
                        acc  <= div_rem_nxt;
                        work <= div_quo_nxt;
                    end
                    if (count == 6'd31) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        count       <= 6'd0;
                        result      <= final_result;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
